// File: rtl/memory_pkg.sv
// memory_pkg: shared sizes and types for the RAM hierarchy.
//   WORD_W      - data word width used by every RAM tier
//   RAM8_ADDR_W - address width of the eight-word tier
//   word_t      - one data word, reused by the larger RAM tiers
package memory_pkg;
    localparam int WORD_W      = 16;
    localparam int RAM8_ADDR_W = 3;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram8_if.sv
// ram8_if: bundles the ram8 data/address/enable signals for benches and
// parent blocks. ram8 itself keeps discrete ports because larger RAMs
// instantiate it positionally.
//   address  - word select
//   data_in  - write data
//   load     - write enable, active-high
//   data_out - word selected by address
// Modports: master drives address/data_in/load, slave returns data_out.
interface ram8_if
    import memory_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
);
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  data_in;
    logic              load;
    logic [WIDTH-1:0]  data_out;

    modport master (output address, output data_in, output load, input data_out);
    modport slave  (input address, input data_in, input load, output data_out);
endinterface

// File: rtl/register16.sv
// register16: WIDTH-bit register with load enable and asynchronous
// active-low clear.
//   CLK     - rising-edge clock
//   RESET_N - async clear, active-low
//   IN      - data captured when LOAD=1
//   LOAD    - load enable
//   OUT     - stored value
module register16
    import memory_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] IN,
    input  logic             LOAD,
    output logic [WIDTH-1:0] OUT
);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            OUT <= '0;
        else if (LOAD)
            OUT <= IN;
    end
endmodule

// File: rtl/ram8.sv
// ram8: eight-word RAM, combinational read, synchronous write,
// asynchronous active-low clear of every word.
//   OUT     - word[ADDRESS], combinational
//   ADDRESS - word select
//   IN      - write data
//   LOAD    - write enable, active-high
//   CLK     - write clock (rising edge)
//   RESET_N - async clear, active-low
// Port order is fixed: larger RAMs instantiate this block positionally.
module ram8
    import memory_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    output logic [WIDTH-1:0]  OUT,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [WIDTH-1:0]  IN,
    input  logic              LOAD,
    input  logic              CLK,
    input  logic              RESET_N
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]            load_vec;
    logic [DEPTH-1:0][WIDTH-1:0] words;

    // One-hot load steering: at most one register sees LOAD per cycle.
    always_comb begin
        load_vec = '0;
        load_vec[ADDRESS] = LOAD;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_reg (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .IN      (IN),
            .LOAD    (load_vec[i]),
            .OUT     (words[i])
        );
    end

    // Read mux; every ADDRESS value maps to a real word.
    assign OUT = words[ADDRESS];
endmodule

// File: tb/tb_ram8.sv
module tb_ram8;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] mem [8];

    ram8_if #(.WIDTH(16), .ADDR_W(3)) bus ();

    ram8 #(.WIDTH(16), .ADDR_W(3)) dut (
        .OUT     (bus.data_out),
        .ADDRESS (bus.address),
        .IN      (bus.data_in),
        .LOAD    (bus.load),
        .CLK     (clk),
        .RESET_N (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] din;
        logic        load;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] a, input logic [15:0] d, input logic l);
        bus.address = a;
        bus.data_in = d;
        bus.load    = l;
    endtask

    // Advance one rising edge, ending 1 time unit after it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
    endtask

    task automatic sweep_model(input string name);
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.address = 3'(k);
            #1;
            check(name, bus.data_out, mem[k]);
        end
    endtask

    vec_t vecs [11];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive(3'd0, 16'h0000, 1'b0);
        clear_model();

        vecs[0]  = '{3'd0, 16'h5555, 1'b0, 16'h0000};
        vecs[1]  = '{3'd0, 16'h5555, 1'b1, 16'h5555};
        vecs[2]  = '{3'd0, 16'hAAAA, 1'b0, 16'h5555};
        vecs[3]  = '{3'd5, 16'hAAAA, 1'b1, 16'hAAAA};
        vecs[4]  = '{3'd0, 16'hFFFF, 1'b0, 16'h5555};
        vecs[5]  = '{3'd1, 16'hFFFF, 1'b0, 16'h0000};
        vecs[6]  = '{3'd2, 16'hFFFF, 1'b0, 16'h0000};
        vecs[7]  = '{3'd3, 16'hFFFF, 1'b0, 16'h0000};
        vecs[8]  = '{3'd4, 16'hFFFF, 1'b0, 16'h0000};
        vecs[9]  = '{3'd6, 16'hFFFF, 1'b0, 16'h0000};
        vecs[10] = '{3'd7, 16'hFFFF, 1'b0, 16'h0000};

        // Reset pulse, then all words read zero.
        #2 rst_n = 1'b0;
        #1 check("reset_during", bus.data_out, 16'h0000);
        edge1();
        rst_n = 1'b1;
        sweep_model("reset_sweep");

        // Table: write/readback and isolation.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].addr, vecs[i].din, vecs[i].load);
            edge1();
            check($sformatf("vec%0d", i), bus.data_out, vecs[i].exp);
        end
        mem[0] = 16'h5555;
        mem[5] = 16'hAAAA;

        // Combinational read: no clock edge between address changes.
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.address = (i % 2 == 0) ? 3'd5 : 3'd0;
            #1;
            check("comb_read", bus.data_out, (i % 2 == 0) ? 16'hAAAA : 16'h5555);
        end

        // Read-during-write, same address: old before edge, new after.
        drive(3'd0, 16'h1234, 1'b1);
        #1 check("rdw_before", bus.data_out, 16'h5555);
        edge1();
        check("rdw_after", bus.data_out, 16'h1234);
        mem[0] = 16'h1234;

        // Write elsewhere is invisible until selected.
        drive(3'd6, 16'hBEEF, 1'b1);
        edge1();
        mem[6] = 16'hBEEF;
        bus.load = 1'b0;
        bus.address = 3'd5;
        #1 check("rdw_other", bus.data_out, 16'hAAAA);
        bus.address = 3'd6;
        #1 check("rdw_other_sel", bus.data_out, 16'hBEEF);

        // Async reset mid-operation with a write pending.
        edge1();
        drive(3'd6, 16'h7777, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("async_rst", bus.data_out, 16'h0000);
        edge1();
        check("rst_blocks_wr", bus.data_out, 16'h0000);
        bus.load = 1'b0;
        #2 rst_n = 1'b1;
        clear_model();
        sweep_model("post_rst_sweep");

        // First write after release.
        drive(3'd3, 16'hC0DE, 1'b1);
        edge1();
        check("first_wr", bus.data_out, 16'hC0DE);
        mem[3] = 16'hC0DE;

        // Full sweep: 16'h1111*(k+1) on 8 consecutive edges.
        for (int k = 0; k < 8; k++) begin
            drive(3'(k), 16'(16'h1111 * (k + 1)), 1'b1);
            edge1();
            mem[k] = 16'(16'h1111 * (k + 1));
        end
        sweep_model("full_sweep");

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  a;
            logic [15:0] d;
            logic        l;
            a = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            l = 1'($urandom_range(0, 1));
            drive(a, d, l);
            #1 check("rand_pre", bus.data_out, mem[a]);
            edge1();
            if (l) mem[a] = d;
            check("rand_post", bus.data_out, mem[a]);
        end
        sweep_model("final_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
